reg_fill_ctrl: RTL

- Write-side front end for the 32x32 register file and its board-level read/display wrapper.
- Turns raw board push-buttons and switches into clean, single-cycle register-file write transactions: `W_Addr`, `W_Data`, `Write_Reg`.
- Supports two write modes:
  - manual single-register writes, with data taken from the codebase's 4-entry constant table;
  - an automatic fill that writes all 32 registers with an address-derived pattern, one per cycle.

---
 rtl/reg_fill_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/reg_fill_ctrl.sv
// Write-side front end for the 32x32 register file: debounces two push-buttons and
// issues single-cycle manual writes or a 32-register automatic fill.

module reg_fill_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic evt_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q;

  // Count consecutive cycles the synchronized value disagrees with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchronizer, debounce state and edge-detect delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 2'b00;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_i};
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign evt_o = level_q & ~level_dly_q;
endmodule

module reg_fill_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] SEED            = 32'h0000_000F
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start_Btn,
  input  logic        Wr_Btn,
  input  logic [4:0]  Sw_Addr,
  input  logic [1:0]  choose,
  output logic [4:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_Reg,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FINISH = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [4:0]  w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic        write_q, write_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_evt, wr_evt;

  function automatic logic [31:0] const_data(input logic [1:0] sel);
    case (sel)
      2'b00:   const_data = 32'h0000_000F;
      2'b01:   const_data = 32'h0000_0DB0;
      2'b10:   const_data = 32'h003C_C381;
      2'b11:   const_data = 32'hFFFF_FFFF;
      default: const_data = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] fill_data(input logic [4:0] a);
    fill_data = SEED + ({27'd0, a} * 32'h0101_0101);
  endfunction

  reg_fill_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk_i(CLK), .rst_ni(Reset), .btn_i(Start_Btn), .evt_o(start_evt)
  );

  reg_fill_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_db (
    .clk_i(CLK), .rst_ni(Reset), .btn_i(Wr_Btn), .evt_o(wr_evt)
  );

  // The start event issues the a=0 write directly so both write kinds share one latency.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    write_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (start_evt) begin
          write_d  = 1'b1;
          busy_d   = 1'b1;
          w_addr_d = 5'd0;
          w_data_d = fill_data(5'd0);
          addr_d   = 5'd1;
          done_d   = 1'b0;
          state_d  = FILL;
        end else if (wr_evt) begin
          write_d  = 1'b1;
          w_addr_d = Sw_Addr;
          w_data_d = const_data(choose);
          done_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        write_d  = 1'b1;
        busy_d   = 1'b1;
        w_addr_d = addr_q;
        w_data_d = fill_data(addr_q);
        addr_d   = addr_q + 5'd1;
        if (addr_q == 5'd31) begin
          state_d = FINISH;
        end else begin
          state_d = FILL;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      addr_q   <= 5'd0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'd0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign W_Addr    = w_addr_q;
  assign W_Data    = w_data_q;
  assign Write_Reg = write_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
endmodule
